// File: rtl/count_mode_ctrl_pkg.sv
// Shared types and helpers for the counter mode controller.
package count_mode_pkg;
    localparam int MODE_W = 2;
    localparam int C_W    = 3;

    typedef enum logic {IDLE, PENDING} state_e;
    typedef logic [MODE_W-1:0] mode_t;

    // dir=1 steps up, dir=0 steps down; wraps naturally mod 4
    function automatic mode_t mode_step(input mode_t mode, input logic dir);
        return dir ? mode + mode_t'(1) : mode - mode_t'(1);
    endfunction
endpackage

// File: rtl/count_mode_ctrl_if.sv
// Button, counter-value and mode signals between the controller and its surroundings.
interface count_mode_ctrl_if
    import count_mode_pkg::*;
    ();
    logic           btn_next;
    logic           btn_prev;
    logic [C_W-1:0] c_in;
    mode_t          A;
    logic           pending;
    logic           mode_changed;

    modport master (output btn_next, btn_prev, c_in, input A, pending, mode_changed);
    modport slave  (input btn_next, btn_prev, c_in, output A, pending, mode_changed);
endinterface

// File: rtl/count_mode_ctrl_btn_debounce.sv
// Two-flop synchronizer, stable-count debouncer and single-cycle rising-edge press.
module btn_debounce #(
    parameter int DEB_CYCLES = 16,
    parameter int DEB_W      = 5
) (
    input  logic clk,
    input  logic res,
    input  logic btn_raw,
    output logic press
);
    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             deb_q, deb_d;
    logic             deb_dly_q, deb_dly_d;
    logic [DEB_W-1:0] cnt_q, cnt_d;

    always_comb begin
        sync1_d   = btn_raw;
        sync2_d   = sync1_q;
        deb_dly_d = deb_q;
        deb_d     = deb_q;
        cnt_d     = '0;
        // the counter runs only while the synced input disagrees with the accepted level
        if (sync2_q != deb_q) begin
            if (cnt_q == DEB_W'(DEB_CYCLES - 1)) deb_d = sync2_q;
            else                                 cnt_d = cnt_q + DEB_W'(1);
        end
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            deb_q     <= 1'b0;
            deb_dly_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            deb_q     <= deb_d;
            deb_dly_q <= deb_dly_d;
            cnt_q     <= cnt_d;
        end
    end

    assign press = deb_q & ~deb_dly_q;
endmodule

// File: rtl/count_mode_ctrl.sv
// Mode controller: debounced next/prev requests, applied to A at a counter sync point or on timeout.
module count_mode_ctrl
    import count_mode_pkg::*;
#(
    parameter int             DEB_CYCLES = 16,
    parameter int             DEB_W      = 5,
    parameter logic [C_W-1:0] SYNC_C     = 3'd0,
    parameter int             TIMEOUT    = 8,
    parameter mode_t          RESET_MODE = 2'b00
) (
    input  logic              clk,
    input  logic              res,
    count_mode_ctrl_if.slave  bus
);
    localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic press_n, press_p, nxt, prv;

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES), .DEB_W(DEB_W)) u_deb_next (
        .clk(clk), .res(res), .btn_raw(bus.btn_next), .press(press_n));
    btn_debounce #(.DEB_CYCLES(DEB_CYCLES), .DEB_W(DEB_W)) u_deb_prev (
        .clk(clk), .res(res), .btn_raw(bus.btn_prev), .press(press_p));

    // coincident presses cancel each other out
    assign nxt = press_n & ~press_p;
    assign prv = press_p & ~press_n;

    state_e           state_q, state_d;
    mode_t            target_q, target_d;
    mode_t            a_q, a_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic             mc_q, mc_d;
    mode_t            stepped;

    assign stepped = mode_step((state_q == IDLE) ? a_q : target_q, nxt);

    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        a_d      = a_q;
        timer_d  = timer_q;
        mc_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (nxt || prv) begin
                    target_d = stepped;
                    timer_d  = '0;
                    state_d  = PENDING;
                end
            end
            PENDING: begin
                if (nxt || prv) begin
                    target_d = stepped;
                    timer_d  = '0;
                    if (stepped == a_q) state_d = IDLE;
                end else if (bus.c_in == SYNC_C || timer_q == TMR_W'(TIMEOUT - 1)) begin
                    a_d     = target_q;
                    state_d = IDLE;
                    mc_d    = 1'b1;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state_q  <= IDLE;
            target_q <= '0;
            a_q      <= RESET_MODE;
            timer_q  <= '0;
            mc_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            a_q      <= a_d;
            timer_q  <= timer_d;
            mc_q     <= mc_d;
        end
    end

    assign bus.A            = a_q;
    assign bus.pending      = (state_q == PENDING);
    assign bus.mode_changed = mc_q;
endmodule

// File: tb/tb_count_mode_ctrl.sv
// Randomized plus directed check of count_mode_ctrl against an in-bench behavioural model.
module tb_count_mode_ctrl;
    localparam int DEB = 4;
    localparam int TMO = 8;

    logic clk = 1'b0;
    logic res = 1'b0;
    int   tests = 0;
    int   fails = 0;
    int   mc_cnt = 0;

    count_mode_ctrl_if bus ();

    count_mode_ctrl #(.DEB_CYCLES(DEB), .DEB_W(5), .SYNC_C(3'd0), .TIMEOUT(TMO), .RESET_MODE(2'b00))
        dut (.clk(clk), .res(res), .bus(bus));

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    int raw_n[$], raw_p[$];      // raw samples, newest last
    int syn_n[$], syn_p[$];      // samples as seen after the two-stage synchronizer
    int lvl_n, lvl_p;            // accepted button levels
    int rose_n, rose_p;          // accepted rising edge on the previous clock
    int m_mode, m_tgt, m_pend, m_age, m_mc;

    function automatic int win_flip(input int s[$], input int lvl);
        if (s.size() < DEB) return 0;
        for (int i = s.size() - DEB; i < s.size(); i++)
            if (s[i] == lvl) return 0;
        return 1;
    endfunction

    task automatic model_reset();
        raw_n = '{0, 0}; raw_p = '{0, 0};
        syn_n.delete(); syn_p.delete();
        lvl_n = 0; lvl_p = 0; rose_n = 0; rose_p = 0;
        m_mode = 0; m_tgt = 0; m_pend = 0; m_age = 0; m_mc = 0;
    endtask

    always @(posedge clk or negedge res) begin
        if (!res) begin
            model_reset();
        end else begin
            int up, dn;
            up = rose_n && !rose_p;
            dn = rose_p && !rose_n;
            m_mc = 0;
            if (!m_pend) begin
                if (up || dn) begin
                    m_tgt = (m_mode + (up ? 1 : 3)) % 4;
                    m_age = 0; m_pend = 1;
                end
            end else if (up || dn) begin
                m_tgt = (m_tgt + (up ? 1 : 3)) % 4;
                m_age = 0;
                if (m_tgt == m_mode) m_pend = 0;
            end else if (bus.c_in == 3'd0 || m_age == TMO - 1) begin
                m_mode = m_tgt; m_pend = 0; m_mc = 1;
            end else begin
                m_age++;
            end
            // synchronizer: what the debouncer sees now was sampled two clocks ago
            syn_n.push_back(raw_n[raw_n.size() - 2]);
            syn_p.push_back(raw_p[raw_p.size() - 2]);
            raw_n.push_back(int'(bus.btn_next));
            raw_p.push_back(int'(bus.btn_prev));
            if (raw_n.size() > 4) begin void'(raw_n.pop_front()); void'(raw_p.pop_front()); end
            if (syn_n.size() > DEB) begin void'(syn_n.pop_front()); void'(syn_p.pop_front()); end
            rose_n = 0; rose_p = 0;
            if (win_flip(syn_n, lvl_n)) begin lvl_n = 1 - lvl_n; rose_n = lvl_n; end
            if (win_flip(syn_p, lvl_p)) begin lvl_p = 1 - lvl_p; rose_p = lvl_p; end
        end
    end

    // ---------------- checking ----------------
    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("A_vs_model",       int'(bus.A),            m_mode);
        chk("pending_vs_model", int'(bus.pending),      m_pend);
        chk("mc_vs_model",      int'(bus.mode_changed), m_mc);
        if (bus.mode_changed === 1'b1) mc_cnt++;
    end

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #2; end
    endtask

    task automatic wait_pend();
        int k;
        for (k = 0; k < 30; k++) begin
            @(negedge clk);
            #1;
            if (bus.pending) break;
        end
        chk("pending_seen", int'(k < 30), 1);
    endtask

    task automatic press_rel(input logic nx, input logic pv);
        bus.btn_next = nx; bus.btn_prev = pv;
        tick(9);
        bus.btn_next = 1'b0; bus.btn_prev = 1'b0;
        tick(9);
    endtask

    initial begin
        int mc0, n;
        bus.btn_next = 1'b0; bus.btn_prev = 1'b0; bus.c_in = 3'd0;
        // 1: reset and idle
        #1;
        chk("rst_A", int'(bus.A), 0);
        chk("rst_pending", int'(bus.pending), 0);
        chk("rst_mc", int'(bus.mode_changed), 0);
        tick(3); res = 1'b1;
        tick(20);
        chk("idle_A", int'(bus.A), 0);
        chk("idle_model_A", m_mode, 0);

        // 2: bouncy next press, then isolated glitch
        mc0 = mc_cnt;
        for (int i = 0; i < 10; i++) begin bus.btn_next = ~bus.btn_next; tick(2); end
        bus.btn_next = 1'b1; tick(15);
        chk("bounce_A", int'(bus.A), 1);
        chk("bounce_pulses", mc_cnt - mc0, 1);
        bus.btn_next = 1'b0; tick(10);
        bus.btn_next = 1'b1; tick(2); bus.btn_next = 1'b0; tick(12);
        chk("glitch_A", int'(bus.A), 1);
        chk("glitch_pulses", mc_cnt - mc0, 1);

        // 3: wrap both directions
        press_rel(1, 0); press_rel(1, 0);
        chk("reach_3", int'(bus.A), 3);
        press_rel(1, 0);
        chk("wrap_next", int'(bus.A), 0);
        chk("wrap_next_model", m_mode, 0);
        press_rel(0, 1);
        chk("wrap_prev", int'(bus.A), 3);
        press_rel(1, 0);
        chk("back_0", int'(bus.A), 0);

        // 4a: timeout with c_in never at sync value
        bus.c_in = 3'd5; mc0 = mc_cnt;
        bus.btn_next = 1'b1;
        wait_pend();
        n = 0;
        while (bus.pending && n < 30) begin n++; @(negedge clk); #1; end
        chk("timeout_len", n, TMO);
        chk("timeout_A", int'(bus.A), 1);
        tick(1); bus.btn_next = 1'b0; tick(10);
        chk("timeout_pulse", mc_cnt - mc0, 1);
        // 4b: sync value arrives on pending cycle 3
        mc0 = mc_cnt;
        bus.btn_next = 1'b1;
        wait_pend();
        @(posedge clk); #2; @(posedge clk); #2;
        bus.c_in = 3'd0;
        tick(1);
        chk("sync3_pending", int'(bus.pending), 0);
        chk("sync3_A", int'(bus.A), 2);
        bus.c_in = 3'd5; bus.btn_next = 1'b0; tick(10);
        chk("sync3_pulse", mc_cnt - mc0, 1);

        // 5: cancel by opposite press, then simultaneous presses
        mc0 = mc_cnt;
        bus.btn_next = 1'b1; tick(2); bus.btn_prev = 1'b1; tick(14);
        chk("cancel_pending", int'(bus.pending), 0);
        chk("cancel_A", int'(bus.A), 2);
        bus.btn_next = 1'b0; bus.btn_prev = 1'b0; tick(10);
        bus.c_in = 3'd0;
        bus.btn_next = 1'b1; bus.btn_prev = 1'b1; tick(14);
        chk("both_A", int'(bus.A), 2);
        chk("both_pending", int'(bus.pending), 0);
        bus.btn_next = 1'b0; bus.btn_prev = 1'b0; tick(10);
        chk("cancel_pulses", mc_cnt - mc0, 0);

        // 6: reset while pending toward mode 2
        press_rel(0, 1);
        chk("pre_rst_A", int'(bus.A), 1);
        bus.c_in = 3'd5; mc0 = mc_cnt;
        bus.btn_next = 1'b1;
        wait_pend();
        chk("pre_rst_target", m_tgt, 2);
        res = 1'b0; #1;
        chk("midrst_A", int'(bus.A), 0);
        chk("midrst_pending", int'(bus.pending), 0);
        chk("midrst_mc", int'(bus.mode_changed), 0);
        bus.btn_next = 1'b0; tick(2); res = 1'b1; tick(20);
        chk("post_rst_A", int'(bus.A), 0);
        chk("post_rst_pending", int'(bus.pending), 0);
        chk("post_rst_pulses", mc_cnt - mc0, 0);

        // random phase
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) bus.btn_next = ~bus.btn_next;
            if ($urandom_range(0, 4) == 0) bus.btn_prev = ~bus.btn_prev;
            bus.c_in = ($urandom_range(0, 3) == 0) ? 3'd0 : 3'($urandom_range(1, 7));
            if ($urandom_range(0, 99) == 0) begin res = 1'b0; tick(1); res = 1'b1; end
            tick($urandom_range(1, 12));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
